seg8_scan_ctrl: RTL and testbench

Eight-digit seven-segment scan controller feeding the hc595 shift-register driver on the hex8 display path. Holds a 32-bit hex value (one nibble per digit) plus per-digit decimal-point and enable masks, time-multiplexes the digits at a fixed refresh rate, and emits one 16-bit {segment, select} word per digit with a single-cycle load strobe (`s_en`). Supports leading-zero blanking so numeric values display without padding.

---
 rtl/seg8_scan_ctrl.sv | 114 +++++++++++
 tb/tb_seg8_scan_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg8_scan_ctrl.sv
// Eight-digit seven-segment scan controller: cycles through the digits at a fixed rate and
// emits one {seg, sel} word per digit with a single-cycle load strobe for the hc595 driver.
module seg8_scan_ctrl #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] disp_data,
    input  logic [7:0]  dp,
    input  logic [7:0]  disp_en,
    input  logic        lz_blank,
    input  logic        update,
    output logic [15:0] data,
    output logic        s_en,
    output logic [2:0]  digit_idx
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [15:0]   BLANK_WORD = 16'hFF00;

    logic [CW-1:0] cnt;
    logic          tick;

    logic [31:0] sh_data;
    logic [7:0]  sh_dp;
    logic [7:0]  sh_en;
    logic        sh_lz;

    logic [2:0]  next_idx;
    logic [4:0]  nib_pos;
    logic [3:0]  nib;
    logic        lead_zero;
    logic        blank;
    logic [7:0]  seg;
    logic [15:0] next_word;

    // Active-low {dp,g,f,e,d,c,b,a} pattern for one hex nibble, decimal point off.
    function automatic logic [7:0] hex_seg(input logic [3:0] n);
        case (n)
            4'h0: hex_seg = 8'hC0;
            4'h1: hex_seg = 8'hF9;
            4'h2: hex_seg = 8'hA4;
            4'h3: hex_seg = 8'hB0;
            4'h4: hex_seg = 8'h99;
            4'h5: hex_seg = 8'h92;
            4'h6: hex_seg = 8'h82;
            4'h7: hex_seg = 8'hF8;
            4'h8: hex_seg = 8'h80;
            4'h9: hex_seg = 8'h90;
            4'hA: hex_seg = 8'h88;
            4'hB: hex_seg = 8'h83;
            4'hC: hex_seg = 8'hC6;
            4'hD: hex_seg = 8'hA1;
            4'hE: hex_seg = 8'h86;
            default: hex_seg = 8'h8E;
        endcase
    endfunction

    assign tick = (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_data <= '0;
            sh_dp   <= '0;
            sh_en   <= '0;
            sh_lz   <= 1'b0;
        end else if (update) begin
            sh_data <= disp_data;
            sh_dp   <= dp;
            sh_en   <= disp_en;
            sh_lz   <= lz_blank;
        end
    end

    // Encode the digit that the next tick will select; a digit is a leading zero when it and
    // every more significant nibble are zero.
    always_comb begin
        next_idx  = digit_idx + 3'd1;
        nib_pos   = {next_idx, 2'b00};
        nib       = sh_data[nib_pos +: 4];
        lead_zero = ((sh_data >> nib_pos) == 32'd0);
        blank     = !sh_en[next_idx] || (sh_lz && (next_idx != 3'd0) && lead_zero);
        seg       = hex_seg(nib) & ~{sh_dp[next_idx], 7'b0};
        next_word = blank ? BLANK_WORD : {seg, 8'b1 << next_idx};
    end

    // NOTE: non-blocking updates mean a tick coinciding with update still encodes from the
    // old shadow values, because the shadows only change at the end of that same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_idx <= 3'd7;
            data      <= BLANK_WORD;
            s_en      <= 1'b0;
        end else begin
            s_en <= tick;
            if (tick) begin
                digit_idx <= next_idx;
                data      <= next_word;
            end
        end
    end

endmodule

// File: tb/tb_seg8_scan_ctrl.sv
// Self-checking bench for seg8_scan_ctrl: directed scenarios plus randomized configurations,
// each strobe compared against a behavioural display model.
module tb_seg8_scan_ctrl;

    localparam int SCAN_DIV = 100;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] disp_data = '0;
    logic [7:0]  dp = '0;
    logic [7:0]  disp_en = '0;
    logic        lz_blank = 1'b0;
    logic        update = 1'b0;
    logic [15:0] data;
    logic        s_en;
    logic [2:0]  digit_idx;

    seg8_scan_ctrl #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .disp_data (disp_data),
        .dp        (dp),
        .disp_en   (disp_en),
        .lz_blank  (lz_blank),
        .update    (update),
        .data      (data),
        .s_en      (s_en),
        .digit_idx (digit_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int last_strobe = 0;
    int exp_idx = 7;

    // Model of what the display should currently be showing.
    logic [31:0] m_data = '0;
    logic [7:0]  m_dp = '0;
    logic [7:0]  m_en = '0;
    logic        m_lz = 1'b0;

    logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    function automatic logic [15:0] model_word(input logic [31:0] d, input logic [7:0] p,
                                               input logic [7:0] e, input logic l, input int i);
        int   nibble;
        logic is_blank;
        logic [7:0] s;
        logic [7:0] sel;
        nibble   = int'((d >> (4 * i)) & 32'hF);
        is_blank = (e[i] == 1'b0) || (l && i > 0 && (d >> (4 * i)) == 32'd0);
        s        = hex_tab[nibble];
        if (p[i]) s = s & 8'h7F;
        sel      = 8'(1 << i);
        return is_blank ? 16'hFF00 : {s, sel};
    endfunction

    // Waits for the next strobe; gap is cycles since the previous strobe, -1 on timeout.
    task automatic next_strobe(output int gap);
        bit found = 0;
        gap = -1;
        for (int k = 0; k < 3 * SCAN_DIV && !found; k++) begin
            @(posedge clk);
            #1;
            if (s_en === 1'b1) begin
                found = 1;
                gap = cyc - last_strobe;
                last_strobe = cyc;
                exp_idx = (exp_idx + 1) % 8;
            end
        end
        if (!found) $display("FAIL strobe_timeout no s_en within %0d cycles", 3 * SCAN_DIV);
    endtask

    task automatic do_update(input logic [31:0] d, input logic [7:0] p, input logic [7:0] e,
                             input logic l);
        disp_data = d;
        dp        = p;
        disp_en   = e;
        lz_blank  = l;
        update    = 1'b1;
        @(posedge clk);
        #1;
        update = 1'b0;
        m_data = d;
        m_dp   = p;
        m_en   = e;
        m_lz   = l;
    endtask

    task automatic model_reset();
        m_data  = '0;
        m_dp    = '0;
        m_en    = '0;
        m_lz    = 1'b0;
        exp_idx = 7;
    endtask

    // Checks one pass worth of strobes against the model (gap, index, word).
    task automatic scan_against_model(input string name, input int n);
        int gap;
        logic [15:0] exp;
        for (int s = 0; s < n; s++) begin
            next_strobe(gap);
            exp = model_word(m_data, m_dp, m_en, m_lz, exp_idx);
            checks++;
            if (gap !== SCAN_DIV) begin
                errors++;
                $display("FAIL %s_gap got %0d expected %0d", name, gap, SCAN_DIV);
            end
            checks++;
            if (digit_idx !== 3'(exp_idx)) begin
                errors++;
                $display("FAIL %s_idx got %0d expected %0d", name, digit_idx, exp_idx);
            end
            checks++;
            if (data !== exp) begin
                errors++;
                $display("FAIL %s_data digit %0d got %h expected %h", name, exp_idx, data, exp);
            end
        end
    endtask

    task automatic test_reset();
        int gap;
        #3 reset = 1'b1;
        #2;
        checks++;
        if (data !== 16'hFF00 || s_en !== 1'b0 || digit_idx !== 3'd7) begin
            errors++;
            $display("FAIL reset_values got %h/%b/%0d expected ff00/0/7", data, s_en, digit_idx);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (data !== 16'hFF00 || s_en !== 1'b0 || digit_idx !== 3'd7) begin
            errors++;
            $display("FAIL reset_hold got %h/%b/%0d expected ff00/0/7", data, s_en, digit_idx);
        end
        reset = 1'b0;
        last_strobe = cyc;
        model_reset();
        next_strobe(gap);
        checks++;
        if (gap !== SCAN_DIV) begin
            errors++;
            $display("FAIL reset_first_strobe got %0d edges expected %0d", gap, SCAN_DIV);
        end
        checks++;
        if (digit_idx !== 3'd0 || data !== 16'hFF00) begin
            errors++;
            $display("FAIL reset_first_word got idx %0d data %h expected 0 ff00", digit_idx, data);
        end
        @(posedge clk);
        #1;
        checks++;
        if (s_en !== 1'b0) begin
            errors++;
            $display("FAIL strobe_width s_en got %b expected 0", s_en);
        end
    endtask

    task automatic test_full_scan();
        logic [15:0] tab [8] = '{16'h8001, 16'hF802, 16'h8204, 16'h9208,
                                 16'h9910, 16'hB020, 16'hA440, 16'hF980};
        do_update(32'h12345678, 8'h00, 8'hFF, 1'b0);
        for (int s = 0; s < 16; s++) begin
            scan_against_model("full_scan", 1);
            checks++;
            if (data !== tab[exp_idx]) begin
                errors++;
                $display("FAIL full_scan_table digit %0d got %h expected %h",
                         exp_idx, data, tab[exp_idx]);
            end
        end
    endtask

    task automatic test_lz_blank();
        logic [15:0] exp;
        do_update(32'h000000A0, 8'h00, 8'hFF, 1'b1);
        for (int s = 0; s < 8; s++) begin
            scan_against_model("lz_a0", 1);
            exp = (exp_idx == 0) ? 16'hC001 : (exp_idx == 1) ? 16'h8802 : 16'hFF00;
            checks++;
            if (data !== exp) begin
                errors++;
                $display("FAIL lz_a0_table digit %0d got %h expected %h", exp_idx, data, exp);
            end
        end
        do_update(32'h00000000, 8'h00, 8'hFF, 1'b1);
        for (int s = 0; s < 8; s++) begin
            scan_against_model("lz_zero", 1);
            exp = (exp_idx == 0) ? 16'hC001 : 16'hFF00;
            checks++;
            if (data !== exp) begin
                errors++;
                $display("FAIL lz_zero_table digit %0d got %h expected %h", exp_idx, data, exp);
            end
        end
    endtask

    task automatic test_mask_dp();
        logic [15:0] exp;
        do_update(32'h88888888, 8'h03, 8'hFE, 1'b0);
        for (int s = 0; s < 8; s++) begin
            scan_against_model("mask_dp", 1);
            if (exp_idx <= 2) begin
                exp = (exp_idx == 0) ? 16'hFF00 : (exp_idx == 1) ? 16'h0002 : 16'h8004;
                checks++;
                if (data !== exp) begin
                    errors++;
                    $display("FAIL mask_dp_table digit %0d got %h expected %h", exp_idx, data, exp);
                end
            end
        end
    endtask

    task automatic test_update_on_tick();
        int gap;
        logic [31:0] old_d;
        logic [15:0] exp;
        old_d = $urandom;
        do_update(old_d, 8'h00, 8'hFF, 1'b0);
        while (exp_idx != 2) scan_against_model("pre_tick", 1);
        // Park update on the tick cycle that precedes the digit-3 strobe.
        repeat (SCAN_DIV - 1) @(posedge clk);
        #1;
        disp_data = 32'hFFFFFFFF;
        update = 1'b1;
        next_strobe(gap);
        update = 1'b0;
        exp = model_word(old_d, 8'h00, 8'hFF, 1'b0, 3);
        checks++;
        if (gap !== SCAN_DIV || digit_idx !== 3'd3 || data !== exp) begin
            errors++;
            $display("FAIL update_tick_old got gap %0d idx %0d data %h expected %0d 3 %h",
                     gap, digit_idx, data, SCAN_DIV, exp);
        end
        m_data = 32'hFFFFFFFF;
        next_strobe(gap);
        checks++;
        if (digit_idx !== 3'd4 || data !== 16'h8E10) begin
            errors++;
            $display("FAIL update_tick_new got idx %0d data %h expected 4 8e10", digit_idx, data);
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        int k;
        for (int t = 0; t < 6; t++) begin
            d = $urandom;
            k = $urandom_range(0, 8);
            if (k == 8) d = '0;
            else d = d & (32'hFFFFFFFF >> (4 * k));
            do_update(d, 8'($urandom), 8'($urandom) | 8'($urandom), 1'($urandom_range(0, 1)));
            scan_against_model("random", 8);
        end
    endtask

    task automatic test_async_reset();
        int gap;
        do_update(32'h9ABCDEF0, 8'h20, 8'hFF, 1'b0);
        while (exp_idx != 5) scan_against_model("pre_reset", 1);
        repeat (10) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        checks++;
        if (data !== 16'hFF00 || s_en !== 1'b0 || digit_idx !== 3'd7) begin
            errors++;
            $display("FAIL async_reset got %h/%b/%0d expected ff00/0/7", data, s_en, digit_idx);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        last_strobe = cyc;
        model_reset();
        next_strobe(gap);
        checks++;
        if (gap !== SCAN_DIV || digit_idx !== 3'd0 || data !== 16'hFF00) begin
            errors++;
            $display("FAIL async_restart got gap %0d idx %0d data %h expected %0d 0 ff00",
                     gap, digit_idx, data, SCAN_DIV);
        end
    endtask

    initial begin
        test_reset();
        test_full_scan();
        test_lz_blank();
        test_mask_dp();
        test_update_on_tick();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
